// File: rtl/btn_conditioner_pkg.sv
// rtl/btn_conditioner_pkg.sv - shared constants and channel state encoding for the button front end
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_RISE = 2'b01,
        ST_HIGH = 2'b10,
        ST_FALL = 2'b11
    } ch_state_e;

    localparam int DB_CYCLES_HW  = 1000000;
    localparam int DB_CYCLES_SIM = 8;

    localparam int P1_UP = 0;
    localparam int P1_DN = 1;
    localparam int P2_UP = 2;
    localparam int P2_DN = 3;

endpackage

// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - raw button inputs and conditioned outputs bundled for the game logic
interface btn_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_press;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, any_press
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button: 2-flop synchroniser, debounce FSM/counter, level and edge pulses
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_HW,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_next
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOW: begin
                if (sync2_q) begin
                    state_d = ST_RISE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RISE: begin
                if (!sync2_q) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync2_q) begin
                    state_d = ST_FALL;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_FALL: begin
                if (sync2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the settled state one clock later, so pulses come only from flops.
        level_d = (state_q == ST_HIGH) || (state_q == ST_FALL);
        press_d = level_d & ~level_q;
        rel_d   = ~level_d & level_q;
    end

    assign level      = level_q;
    assign press      = press_q;
    assign rel        = rel_q;
    assign press_next = press_d;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N_BTN independent debounce channels plus a registered any_press summary
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int DB_CYCLES = DB_CYCLES_HW,
    parameter int CNT_W     = 20
) (
    input  logic               clk,
    input  logic               reset,
    btn_conditioner_if.slave   bus
);
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] press_next;
    logic             any_press_q, any_press_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .raw        (bus.btn_raw[i]),
            .level      (level[i]),
            .press      (press[i]),
            .rel        (rel[i]),
            .press_next (press_next[i])
        );
    end

    // OR the channels' next-cycle press so any_press lands in the same cycle as btn_press.
    always_comb begin
        any_press_d = |press_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.any_press   = any_press_q;

endmodule
